// File: rtl/leader_frame_builder_pkg.sv
// Shared widths and sequencer state encoding for the leader frame builder.
package leader_frame_builder_pkg;
  localparam int SYM_W  = 2;
  localparam int T_W    = 5;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/leader_word_fifo.sv
// Two-entry word FIFO; the head lives in its own register so data_out is registered.
module leader_word_fifo
  import leader_frame_builder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);
  logic [WORD_W-1:0] head_q;
  logic [WORD_W-1:0] tail_q;
  logic [1:0]        count_q;
  logic              do_pop;
  logic              do_push;

  assign empty    = (count_q == 2'd0);
  assign full     = (count_q == 2'd2);
  assign count    = count_q;
  assign data_out = head_q;
  assign do_pop   = !empty && pop_ready;
  // A full FIFO still accepts a push on the edge it pops.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= push_data;
          end else begin
            head_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/leader_frame_builder.sv
// Sweeps t over one frame, packs the returned leader symbols into words and
// streams them out through a small FIFO with backpressure.
module leader_frame_builder
  import leader_frame_builder_pkg::*;
#(
  parameter int NUM_SYMS      = 32,
  parameter int SYMS_PER_WORD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [T_W-1:0]    t_out,
  input  logic [SYM_W-1:0]  l_in,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done
);
  if (SYMS_PER_WORD != 16 || NUM_SYMS < 1 || NUM_SYMS > 32) begin : g_bad_param
    $error("leader_frame_builder: illegal NUM_SYMS or SYMS_PER_WORD");
  end

  localparam logic [T_W-1:0] LAST_T = T_W'(NUM_SYMS - 1);

  state_e            state_q;
  logic [WORD_W-1:0] pack_q;
  logic [3:0]        slot;
  logic [WORD_W-1:0] sym_word;
  logic [WORD_W-1:0] push_data;
  logic              word_end;
  logic              stall;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;

  assign slot       = t_out[3:0];
  assign sym_word   = WORD_W'(l_in) << {slot, 1'b0};
  assign push_data  = pack_q | sym_word;
  assign word_end   = (slot == 4'd15) || (t_out == LAST_T);
  assign word_valid = !fifo_empty;
  assign pop        = word_valid && word_ready;
  assign stall      = word_end && fifo_full && !pop;
  assign push       = (state_q == S_RUN) && word_end && !stall;
  assign busy       = (state_q != S_IDLE);
  // Asserted during the cycle the last word is accepted, so it lines up with the handshake.
  assign done       = (state_q == S_DRAIN) && pop && (fifo_count == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_out   <= '0;
      pack_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            t_out   <= '0;
            pack_q  <= '0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            pack_q <= word_end ? '0 : push_data;
            if (t_out == LAST_T) state_q <= S_DRAIN;
            else                 t_out   <= t_out + T_W'(1);
          end
        end
        S_DRAIN: begin
          if (pop && fifo_count == 2'd1) begin
            state_q <= S_IDLE;
            t_out   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  leader_word_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop_ready (word_ready),
    .data_out  (word_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
endmodule

// File: doc/leader_frame_builder.md
Name: leader_frame_builder

Overview:
- Upstream/downstream companion to leader_generator. Sweeps the 5-bit index t over one frame and drives it into leader_generator.
- Captures each returned 2-bit leader symbol l in the same cycle and packs the symbols into 32-bit words.
- Words go out on a valid/ready stream to the frame sink.
- Replaces the free-running testbench counter with a synthesizable sequencer that supports backpressure.

Parameters:
- NUM_SYMS, 32: symbols per frame. Legal range 1..32. t sweeps 0..NUM_SYMS-1.
- SYMS_PER_WORD, 16: 2-bit symbols packed per 32-bit output word. Fixed at 16; any other value is illegal.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to build a frame; honoured only in IDLE
- t_out  out  5  index presented to leader_generator
- l_in  in  2  leader symbol from leader_generator; combinational function of t_out, sampled on the same edge
- word_data  out  32  packed word. Symbol k of the word sits at bits [2k+1:2k].
- word_valid  out  1  word_data holds a valid word
- word_ready  in  1  sink accepts the word when word_valid && word_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last word of the frame is accepted

Behaviour:
- Reset (async assert, synchronous deassert handled outside the block): state=IDLE, t_out=0, pack register=0, slot count=0, FIFO empty, word_valid=0, busy=0, done=0.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start. t_out=0, pack register cleared.
- RUN, each cycle without a stall:
  - l_in is written into pack slot (t_out mod 16).
  - t_out increments.
  - A word is complete when the slot is 15 or when t_out==NUM_SYMS-1. A partial final word has its unused upper slots zero-padded.
  - A completed word is pushed into a 2-entry output FIFO on the same edge, and the pack register is cleared.
- Stall: if completing a word would push into a FIFO that is full and not popping on that edge, then t_out, the slot count and the pack register all hold. l_in is re-sampled on the next edge; leader_generator is combinational, so the value is identical.
- RUN -> DRAIN on the edge that pushes the final word.
- DRAIN -> IDLE when the FIFO becomes empty. done pulses on that same pop edge, and t_out returns to 0.
- FIFO:
  - Simultaneous push and pop on the same edge is allowed when the FIFO is full.
  - word_valid equals FIFO not-empty. word_data is the FIFO head, registered.
  - Head-of-line word_data must remain stable while word_valid && !word_ready.
- Latency: the first word is valid 17 cycles after start is sampled (1 cycle to enter RUN plus 16 symbol cycles) when there is no backpressure.
- start while busy is ignored. There is no abort; only rst_n stops a frame.
- Reset asserted mid-frame: all state clears immediately, and a word in flight is discarded.
- word_ready while word_valid=0 has no effect.
- t_out wraps only through the explicit return to 0; it never counts past NUM_SYMS-1.

Decomposition:
- Shared package / include header:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2)
  - SYM_W=2, T_W=5, WORD_W=32
- One sub-module: leader_word_fifo, a 2-entry, 32-bit, valid/ready FIFO with full/empty flags.
- The sequencer and packer stay in the top module.

Test Plan:
- Stub l=t[1:0], word_ready held 1, pulse start:
  - word 0xE4E4E4E4 accepted at cycle 17, then 0xE4E4E4E4 at cycle 33
  - done pulses together with the second acceptance
  - busy low afterwards
- Stub l=t[4:3], word_ready held 1 -> words 0x55550000 then 0xFFFFAAAA.
- Stub l=t[1:0], word_ready=0 until cycle 60:
  - t_out freezes at 31 with the FIFO holding both words
  - word_data stable at 0xE4E4E4E4
  - after ready rises, both words drain in order, then done
- NUM_SYMS=20, stub l=2'b11 -> words 0xFFFFFFFF then 0x000000FF, then done.
- rst_n pulled low at t_out=9:
  - all outputs return to reset values asynchronously
  - a new start gives a full, correct frame beginning at t_out=0
- start pulsed while busy (cycle 5) and again in DRAIN -> ignored; exactly two words and one done pulse per frame.
